lfsr_seq_ctrl: RTL and testbench
================================

Name: lfsr_seq_ctrl

Overview:
Sequencer for the team's serial-output LFSR, which has a seed-select mux, a global write-enable, and a registered 1-bit output. On a start request it does three things in order: loads a seed, runs a configurable warm-up with discarded bits, then packs the serial bit stream into WORD_WIDTH-bit words. Words are delivered over a valid/ready interface, with the LFSR frozen whenever the consumer stalls. The block sits between the LFSR and downstream consumers such as the BIST pattern sink and scrambler.

Parameters:
DEGREE, 35, LFSR length and seed width
WORD_WIDTH, 16, output word width in bits (>=2)
CNT_WIDTH, 16, width of the word-count request
WARMUP_CYCLES, 35, LFSR steps discarded after seeding (>=1; the LFSR output register lags one step)

Ports:
Clk_CI  in  1  clock, rising edge
Rst_RBI  in  1  asynchronous active-low reset
Start_SI  in  1  start request, sampled only in IDLE
Seed_DI  in  DEGREE  seed, latched with Start_SI
NumWords_DI  in  CNT_WIDTH  number of words to produce, latched with Start_SI
Abort_SI  in  1  abort the current run
LfsrBit_DI  in  1  LFSR serial output
LfsrWrEn_SO  out  1  LFSR write-enable
LfsrSeedWr_SO  out  1  LFSR seed-select
LfsrSeed_DO  out  DEGREE  seed to the LFSR (latched copy)
Word_DO  out  WORD_WIDTH  packed output word
Valid_SO  out  1  Word_DO valid
Ready_SI  in  1  consumer ready
Busy_SO  out  1  high in every state except IDLE
Done_SO  out  1  one-cycle pulse at the end of a completed run

Behaviour:
- Reset: all registered state clears immediately; state=IDLE.
  - All outputs 0; Word_DO=0; LfsrSeed_DO=0.
  - Word and remaining counters cleared.
- IDLE:
  - Start_SI=1 and NumWords_DI!=0: latch Seed_DI and NumWords_DI, go to LOAD.
  - Start_SI=1 and NumWords_DI==0: pulse Done_SO next cycle, stay IDLE, LFSR untouched.
- LOAD (1 cycle): LfsrSeedWr_SO=1, LfsrWrEn_SO=1, then go to WARM.
- WARM (WARMUP_CYCLES cycles):
  - LfsrWrEn_SO=1, LfsrSeedWr_SO=0.
  - Bits are ignored.
  - When the counter expires, go to FILL.
- FILL (WORD_WIDTH cycles):
  - LfsrWrEn_SO=1 every cycle.
  - Each cycle samples exactly one bit: Word={Word[WORD_WIDTH-2:0], LfsrBit_DI}. The first-sampled bit ends in the MSB.
  - After the WORD_WIDTH-th sample, go to HOLD.
- HOLD:
  - Valid_SO=1, LfsrWrEn_SO=0. The LFSR is frozen, so no bit is lost or duplicated across stalls.
  - Word_DO is stable while Valid_SO=1 and Ready_SI=0.
  - On Valid_SO&Ready_SI, decrement the remaining count:
    - remaining was 1: go to IDLE and pulse Done_SO in the following cycle.
    - otherwise: go to FILL.
  - Valid_SO drops the cycle after the handshake.
- Latency: Start_SI sampled at edge 0 gives first Valid_SO in cycle 2+WARMUP_CYCLES+WORD_WIDTH (53 with defaults). Each later word takes WORD_WIDTH cycles after its handshake.
- Abort_SI=1 in any non-IDLE state:
  - Next state is IDLE; Valid_SO and LfsrWrEn_SO go to 0 next cycle.
  - No Done_SO pulse.
  - Abort takes priority over a same-cycle handshake; that word counts as not delivered.
- Start_SI outside IDLE is ignored. Abort_SI in IDLE is ignored. Start and Abort together in IDLE: abort wins and the start is ignored.
- Counters:
  - Remaining count is CNT_WIDTH wide; it never wraps because it is only decremented while nonzero.
  - Warm-up/bit counter is sized $clog2(max(WARMUP_CYCLES, WORD_WIDTH)+1).

Optional Feature:
LFSR_SEED_ZERO_GUARD_EN
- Defined: an all-zero Seed_DI latched at start is replaced by DEGREE'(1). Adds output SeedErr_SO, set at the latch and cleared on the next accepted Start_SI or on reset.
- Undefined: the seed is passed through unchanged and there is no SeedErr_SO port. An all-zero seed yields all-zero words.

Test Plan:
- Seed=1, NumWords=1, Ready=1, defaults:
  - Valid_SO first high in cycle 53.
  - Word_DO equals bits 36..51 of the golden x^35+x^2+1 model stream, MSB-first.
  - Done_SO pulses in cycle 55; Busy_SO is low from cycle 55.
- Seed=35'h5A5A5A5A5, NumWords=3, Ready=1:
  - Three words, 17 cycles apart, contiguous with the golden stream.
  - LfsrWrEn_SO high for exactly 1+35+48 cycles.
- NumWords=2, Ready held 0 for 10 cycles on word 1:
  - Word_DO stable and LfsrWrEn_SO=0 throughout the stall.
  - Word 2 is still contiguous with word 1.
- Abort_SI pulsed in the 5th FILL cycle:
  - IDLE next cycle; Valid_SO, LfsrWrEn_SO and Done_SO all 0.
  - A new Start with seed 1 then reproduces the first test exactly.
- NumWords=0 → Done_SO pulse next cycle; LfsrWrEn_SO and LfsrSeedWr_SO never asserted.
- Rst_RBI asserted mid-FILL:
  - All outputs 0 immediately (asynchronous).
  - Seed=0 with LFSR_SEED_ZERO_GUARD_EN defined: SeedErr_SO=1, LfsrSeed_DO=1. Without the macro: words are 16'h0000.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the serial-output LFSR: seeds it, discards a warm-up run, then packs bits into words on a valid/ready port.
// Optional build macro LFSR_SEED_ZERO_GUARD_EN replaces an all-zero seed with 1 and adds SeedErr_SO.
module lfsr_seq_ctrl #(
    parameter int DEGREE        = 35,
    parameter int WORD_WIDTH    = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int WARMUP_CYCLES = 35
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Start_SI,
    input  logic [DEGREE-1:0]     Seed_DI,
    input  logic [CNT_WIDTH-1:0]  NumWords_DI,
    input  logic                  Abort_SI,
    input  logic                  LfsrBit_DI,
    output logic                  LfsrWrEn_SO,
    output logic                  LfsrSeedWr_SO,
    output logic [DEGREE-1:0]     LfsrSeed_DO,
    output logic [WORD_WIDTH-1:0] Word_DO,
    output logic                  Valid_SO,
    input  logic                  Ready_SI,
    output logic                  Busy_SO,
    output logic                  Done_SO
`ifdef LFSR_SEED_ZERO_GUARD_EN
    ,
    output logic                  SeedErr_SO
`endif
);

    localparam int BIT_MAX   = (WARMUP_CYCLES > WORD_WIDTH) ? WARMUP_CYCLES : WORD_WIDTH;
    localparam int BIT_CNT_W = $clog2(BIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARM,
        FILL,
        HOLD
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   remain_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [WORD_WIDTH-1:0]  word_q;
    logic                   finish_q;
    logic [DEGREE-1:0]      seed_sel;

`ifdef LFSR_SEED_ZERO_GUARD_EN
    // An all-zero seed would lock the LFSR; substitute the smallest legal seed.
    assign seed_sel = (Seed_DI == '0) ? DEGREE'(1) : Seed_DI;
`else
    assign seed_sel = Seed_DI;
`endif

    assign Word_DO = word_q;

    // NOTE: every output is a flop updated together with the state, so all of
    // them change on the same edge as the transition that implies them.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q       <= IDLE;
            remain_q      <= '0;
            bit_cnt_q     <= '0;
            word_q        <= '0;
            finish_q      <= 1'b0;
            LfsrWrEn_SO   <= 1'b0;
            LfsrSeedWr_SO <= 1'b0;
            LfsrSeed_DO   <= '0;
            Valid_SO      <= 1'b0;
            Busy_SO       <= 1'b0;
            Done_SO       <= 1'b0;
`ifdef LFSR_SEED_ZERO_GUARD_EN
            SeedErr_SO    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout; a later assignment in this block
            // deliberately overrides an earlier default for the same edge.
            Done_SO  <= finish_q;
            finish_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    Busy_SO <= 1'b0;
                    if (Start_SI && !Abort_SI) begin
`ifdef LFSR_SEED_ZERO_GUARD_EN
                        SeedErr_SO <= 1'b0;
`endif
                        if (NumWords_DI != '0) begin
                            LfsrSeed_DO   <= seed_sel;
                            remain_q      <= NumWords_DI;
                            state_q       <= LOAD;
                            LfsrWrEn_SO   <= 1'b1;
                            LfsrSeedWr_SO <= 1'b1;
                            Busy_SO       <= 1'b1;
`ifdef LFSR_SEED_ZERO_GUARD_EN
                            SeedErr_SO    <= (Seed_DI == '0);
`endif
                        end else begin
                            Done_SO <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    LfsrSeedWr_SO <= 1'b0;
                    bit_cnt_q     <= BIT_CNT_W'(WARMUP_CYCLES - 1);
                    state_q       <= WARM;
                end

                WARM: begin
                    if (bit_cnt_q == '0) begin
                        bit_cnt_q <= BIT_CNT_W'(WORD_WIDTH - 1);
                        state_q   <= FILL;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end

                FILL: begin
                    word_q <= {word_q[WORD_WIDTH-2:0], LfsrBit_DI};
                    if (bit_cnt_q == '0) begin
                        LfsrWrEn_SO <= 1'b0;
                        Valid_SO    <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end

                HOLD: begin
                    if (Valid_SO && Ready_SI) begin
                        Valid_SO <= 1'b0;
                        remain_q <= remain_q - CNT_WIDTH'(1);
                        if (remain_q == CNT_WIDTH'(1)) begin
                            // Busy stays high for the cycle that carries the finish flag.
                            finish_q <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            LfsrWrEn_SO <= 1'b1;
                            bit_cnt_q   <= BIT_CNT_W'(WORD_WIDTH - 1);
                            state_q     <= FILL;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase

            // Abort beats everything, including a handshake on the same edge.
            if (Abort_SI && state_q != IDLE) begin
                state_q       <= IDLE;
                LfsrWrEn_SO   <= 1'b0;
                LfsrSeedWr_SO <= 1'b0;
                Valid_SO      <= 1'b0;
                Busy_SO       <= 1'b0;
                finish_q      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural x^35+x^2+1 LFSR attached to its LFSR port.
// Golden stream bit k (1-based) is bit 0 of the LFSR state after k-1 steps from the seed.
module tb_lfsr_seq_ctrl;

    logic        Clk_CI = 1'b0;
    logic        Rst_RBI;
    logic        Start_SI;
    logic [34:0] Seed_DI;
    logic [15:0] NumWords_DI;
    logic        Abort_SI;
    logic        LfsrBit_DI = 1'b0;
    logic        LfsrWrEn_SO;
    logic        LfsrSeedWr_SO;
    logic [34:0] LfsrSeed_DO;
    logic [15:0] Word_DO;
    logic        Valid_SO;
    logic        Ready_SI;
    logic        Busy_SO;
    logic        Done_SO;
`ifdef LFSR_SEED_ZERO_GUARD_EN
    logic        SeedErr_SO;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_seq_ctrl dut (
        .Clk_CI        (Clk_CI),
        .Rst_RBI       (Rst_RBI),
        .Start_SI      (Start_SI),
        .Seed_DI       (Seed_DI),
        .NumWords_DI   (NumWords_DI),
        .Abort_SI      (Abort_SI),
        .LfsrBit_DI    (LfsrBit_DI),
        .LfsrWrEn_SO   (LfsrWrEn_SO),
        .LfsrSeedWr_SO (LfsrSeedWr_SO),
        .LfsrSeed_DO   (LfsrSeed_DO),
        .Word_DO       (Word_DO),
        .Valid_SO      (Valid_SO),
        .Ready_SI      (Ready_SI),
        .Busy_SO       (Busy_SO),
        .Done_SO       (Done_SO)
`ifdef LFSR_SEED_ZERO_GUARD_EN
        ,
        .SeedErr_SO    (SeedErr_SO)
`endif
    );

    always #5 Clk_CI = ~Clk_CI;

    function automatic logic [34:0] lfsr_step(input logic [34:0] s);
        return {s[33:0], s[34] ^ s[1]};
    endfunction

    // Behavioural LFSR: seed-select mux, write-enable, registered output bit.
    logic [34:0] lfsr_q = '0;
    logic [34:0] lfsr_nxt;
    assign lfsr_nxt = LfsrSeedWr_SO ? LfsrSeed_DO : lfsr_step(lfsr_q);
    always @(posedge Clk_CI) begin
        if (LfsrWrEn_SO) begin
            lfsr_q     <= lfsr_nxt;
            LfsrBit_DI <= lfsr_nxt[0];
        end
    end

    // Word idx covers golden stream bits 36+16*idx .. 51+16*idx, first bit in the MSB.
    function automatic logic [15:0] golden_word(input logic [34:0] seed, input int idx);
        logic [34:0] g = seed;
        logic [15:0] w = '0;
        for (int k = 1; k <= 51 + 16 * idx; k++) begin
            if (k >= 36 + 16 * idx) w = {w[14:0], g[0]};
            g = lfsr_step(g);
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the most recent run, cycle 1 being the one right after the start edge.
    int          first_valid, done_cyc, busy_low_cyc, wren_cnt, seedwr_cnt, stall_bad;
    bit          finished;
    logic [3:0]  abort_snap;
    logic [15:0] words[$];
    int          word_cycs[$];

    task automatic run(input logic [34:0] seed, input int n, input int stall_len, input int abort_cyc);
        int          stall_left;
        logic [15:0] held;
        first_valid = 0; done_cyc = 0; busy_low_cyc = 0; wren_cnt = 0; seedwr_cnt = 0;
        stall_bad = 0; finished = 1'b0; abort_snap = 4'hf; held = '0;
        words.delete();
        word_cycs.delete();
        @(negedge Clk_CI);
        Start_SI    = 1'b1;
        Seed_DI     = seed;
        NumWords_DI = 16'(n);
        @(posedge Clk_CI);
        @(negedge Clk_CI);
        Start_SI   = 1'b0;
        stall_left = stall_len;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (LfsrWrEn_SO) wren_cnt++;
            if (LfsrSeedWr_SO) seedwr_cnt++;
            if (Done_SO && done_cyc == 0) done_cyc = cyc;
            if (!Busy_SO && busy_low_cyc == 0) busy_low_cyc = cyc;
            if (Valid_SO && first_valid == 0) first_valid = cyc;
            if (cyc == abort_cyc + 1) abort_snap = {Busy_SO, Valid_SO, LfsrWrEn_SO, Done_SO};
            Ready_SI = 1'b1;
            Abort_SI = (cyc == abort_cyc);
            if (Valid_SO && words.size() == 0 && stall_len > 0) begin
                if (stall_left == stall_len) held = Word_DO;
                else if (Word_DO !== held) stall_bad++;
                if (LfsrWrEn_SO) stall_bad++;
                if (stall_left > 0) begin
                    Ready_SI = 1'b0;
                    stall_left--;
                end
            end
            if (Valid_SO && Ready_SI && !Abort_SI) begin
                words.push_back(Word_DO);
                word_cycs.push_back(cyc);
            end
            if (done_cyc != 0 || (abort_cyc != 0 && cyc == abort_cyc + 4)) begin
                finished = 1'b1;
                break;
            end
            @(negedge Clk_CI);
        end
        Abort_SI = 1'b0;
        Ready_SI = 1'b1;
    endtask

    task automatic check_seed1_run(input string tag);
        run(35'h1, 1, 0, 0);
        check({tag, " finished"}, 64'(finished), 64'(1));
        check({tag, " first valid cycle"}, 64'(first_valid), 64'(53));
        check({tag, " word count"}, 64'(words.size()), 64'(1));
        check({tag, " word0"}, 64'(words[0]), 64'(golden_word(35'h1, 0)));
        check({tag, " done cycle"}, 64'(done_cyc), 64'(55));
        check({tag, " busy low cycle"}, 64'(busy_low_cyc), 64'(55));
        check({tag, " wren cycles"}, 64'(wren_cnt), 64'(52));
        check({tag, " seedwr cycles"}, 64'(seedwr_cnt), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_RBI = 1'b0; Start_SI = 1'b0; Seed_DI = '0; NumWords_DI = '0;
        Abort_SI = 1'b0; Ready_SI = 1'b1;
        #3;
        check("reset ctrl outputs", 64'({Valid_SO, LfsrWrEn_SO, LfsrSeedWr_SO, Busy_SO, Done_SO}), 64'(0));
        check("reset word", 64'(Word_DO), 64'(0));
        check("reset seed", 64'(LfsrSeed_DO), 64'(0));
        repeat (2) @(negedge Clk_CI);
        Rst_RBI = 1'b1;

        check_seed1_run("single");

        run(35'h5A5A5A5A5, 3, 0, 0);
        check("multi finished", 64'(finished), 64'(1));
        check("multi word count", 64'(words.size()), 64'(3));
        check("multi first valid", 64'(first_valid), 64'(53));
        check("multi gap 0-1", 64'(word_cycs[1] - word_cycs[0]), 64'(17));
        check("multi gap 1-2", 64'(word_cycs[2] - word_cycs[1]), 64'(17));
        for (int i = 0; i < 3; i++)
            check($sformatf("multi word%0d", i), 64'(words[i]), 64'(golden_word(35'h5A5A5A5A5, i)));
        check("multi wren cycles", 64'(wren_cnt), 64'(84));

        run(35'h123456789, 2, 10, 0);
        check("stall finished", 64'(finished), 64'(1));
        check("stall word/wren steady", 64'(stall_bad), 64'(0));
        check("stall accept cycle", 64'(word_cycs[0]), 64'(63));
        check("stall word0", 64'(words[0]), 64'(golden_word(35'h123456789, 0)));
        check("stall word1", 64'(words[1]), 64'(golden_word(35'h123456789, 1)));
        check("stall wren cycles", 64'(wren_cnt), 64'(68));

        run(35'h1, 1, 0, 41);
        check("abort outputs next cycle", 64'(abort_snap), 64'(0));
        check("abort no done", 64'(done_cyc), 64'(0));
        check("abort no word", 64'(words.size()), 64'(0));
        check_seed1_run("after abort");

        run(35'h7, 0, 0, 0);
        check("zero count done cycle", 64'(done_cyc), 64'(1));
        check("zero count wren", 64'(wren_cnt + seedwr_cnt), 64'(0));
        repeat (3) @(negedge Clk_CI);
        check("zero count quiet", 64'({Done_SO, Busy_SO, LfsrWrEn_SO, LfsrSeedWr_SO}), 64'(0));
        check("zero count seed kept", 64'(LfsrSeed_DO), 64'(1));

        run(35'h0, 1, 0, 0);
        check("seed0 finished", 64'(finished), 64'(1));
`ifdef LFSR_SEED_ZERO_GUARD_EN
        check("seed0 seed err", 64'(SeedErr_SO), 64'(1));
        check("seed0 lfsr seed", 64'(LfsrSeed_DO), 64'(1));
        check("seed0 word", 64'(words[0]), 64'(golden_word(35'h1, 0)));
`else
        check("seed0 lfsr seed", 64'(LfsrSeed_DO), 64'(0));
        check("seed0 word count", 64'(words.size()), 64'(1));
        check("seed0 word", 64'(words[0]), 64'(0));
`endif

        // Reset in the 9th FILL cycle (cycle 45).
        @(negedge Clk_CI);
        Start_SI = 1'b1; Seed_DI = 35'h5A5A5A5A5; NumWords_DI = 16'd1;
        @(posedge Clk_CI);
        @(negedge Clk_CI);
        Start_SI = 1'b0;
        repeat (44) @(negedge Clk_CI);
        check("pre-reset mid fill", 64'({Busy_SO, LfsrWrEn_SO, Valid_SO}), 64'(3'b110));
        #2 Rst_RBI = 1'b0;
        #1;
        check("async reset ctrl", 64'({Valid_SO, LfsrWrEn_SO, LfsrSeedWr_SO, Busy_SO, Done_SO}), 64'(0));
        check("async reset word", 64'(Word_DO), 64'(0));
        check("async reset seed", 64'(LfsrSeed_DO), 64'(0));
`ifdef LFSR_SEED_ZERO_GUARD_EN
        check("async reset seed err", 64'(SeedErr_SO), 64'(0));
`endif
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        repeat (2) @(negedge Clk_CI);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
